// File: rtl/lcd_capture_if.sv
// rtl/lcd_capture_if.sv - framebuffer write bus between lcd_capture and its sink
interface lcd_capture_if;
  logic [12:0] fb_adr;
  logic [7:0]  fb_data;
  logic        fb_valid;
  logic        fb_ready;

  modport master (output fb_adr, output fb_data, output fb_valid, input fb_ready);
  modport slave  (input fb_adr, input fb_data, input fb_valid, output fb_ready);
endinterface

// File: rtl/lcd_capture.sv
// rtl/lcd_capture.sv - packs 160x144 2-bit LCD pixels into framebuffer byte writes through a small FIFO
module lcd_capture #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          disp_on,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          px_out,
  input  logic [1:0]    px,
  lcd_capture_if.master fb,
  output logic          frame_done,
  output logic          overflow
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [7:0]  X_END    = 8'd160;
  localparam logic [7:0]  Y_END    = 8'd144;
  localparam logic [12:0] LAST_ADR = 13'd5759;
  localparam logic [AW:0] DEPTH    = (AW+1)'(FIFO_DEPTH);

  logic [7:0]    x_q, x_d;
  logic [7:0]    y_q, y_d;
  logic [1:0]    pack_q, pack_d;
  logic [5:0]    sh_q, sh_d;
  logic [12:0]   adr_q, adr_d;
  logic [20:0]   mem_q [FIFO_DEPTH];
  logic [20:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          fd_q, fd_d;

  logic          push, wr, pop, full;
  logic [20:0]   entry;
  logic [20:0]   head;

  assign head        = mem_q[rd_ptr_q];
  assign fb.fb_adr   = head[20:8];
  assign fb.fb_data  = head[7:0];
  assign fb.fb_valid = (cnt_q != '0);
  assign frame_done  = fd_q;
  assign overflow    = ovf_q;

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    pack_d   = pack_q;
    sh_d     = sh_q;
    adr_d    = adr_q;
    ovf_d    = ovf_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    entry    = '0;

    pop  = (cnt_q != '0) && fb.fb_ready;
    full = (cnt_q == DEPTH);

    if (!disp_on) begin
      x_d    = '0;
      y_d    = '0;
      pack_d = '0;
      adr_d  = '0;
    end else begin
      // Line/frame clears happen first so a pixel in the hsync clk lands at x=0.
      if (hsync) begin
        x_d    = '0;
        pack_d = '0;
        if (vsync) begin
          y_d   = '0;
          adr_d = '0;
        end else if (x_q == X_END && y_q != Y_END) begin
          y_d = y_q + 8'd1;
        end
      end
      if (px_out) begin
        if (x_d < X_END && y_d < Y_END) begin
          sh_d = {sh_q[3:0], px};
          x_d  = x_d + 8'd1;
          if (pack_d == 2'd3) begin
            push   = 1'b1;
            entry  = {adr_d, sh_q, px};
            adr_d  = adr_d + 13'd1;
            pack_d = '0;
          end else begin
            pack_d = pack_d + 2'd1;
          end
        end else begin
          ovf_d = 1'b1;
        end
      end
    end

    // A full FIFO still accepts a push when the head leaves in the same clk.
    wr = push && (!full || pop);
    if (push && !wr) begin
      ovf_d = 1'b1;
    end

    if (wr) begin
      mem_d[wr_ptr_q] = entry;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (wr && !pop) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (!wr && pop) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end

    fd_d = pop && (head[20:8] == LAST_ADR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q      <= '0;
      y_q      <= '0;
      pack_q   <= '0;
      sh_q     <= '0;
      adr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      fd_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      pack_q   <= pack_d;
      sh_q     <= sh_d;
      adr_q    <= adr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      fd_q     <= fd_d;
      mem_q    <= mem_d;
    end
  end

endmodule
